// File: rtl/fifo_rd_stream.sv
// Read-domain drain adapter: pulls words from an async FIFO through r_en/empty
// and presents them as a valid/ready stream via a 2-entry skid buffer.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_r,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   input  logic                  flush,
   output logic [CNT_WIDTH-1:0]  words_out
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   head_q, head_d;
   logic [DATA_WIDTH-1:0]   tail_q, tail_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic                    push;
   logic                    pop;

   // Read enable looks only at occupancy and inputs, so m_ready never reaches fifo_r_en.
   always_comb begin
      push      = !rst && !flush && !fifo_empty && (state_q != ST_TWO);
      pop       = m_valid_q && m_ready;
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d = ST_ONE;
                  head_d  = fifo_data;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  state_d = ST_ONE;
                  head_d  = fifo_data;
               end else if (push) begin
                  state_d = ST_TWO;
                  tail_d  = fifo_data;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d = ST_ONE;
                  head_d  = tail_q;
               end else begin
                  state_d = ST_TWO;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      if (pop) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
      // Outputs are registered from next-state so they track occupancy exactly.
      m_valid_d = (state_d != ST_EMPTY);
      if (m_valid_d) begin
         m_data_d = head_d;
      end else begin
         m_data_d = {DATA_WIDTH{1'b0}};
      end
   end

   // Buffer, occupancy and counter registers with synchronous reset.
   always_ff @(posedge clk_r) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         head_q    <= {DATA_WIDTH{1'b0}};
         tail_q    <= {DATA_WIDTH{1'b0}};
         cnt_q     <= {CNT_WIDTH{1'b0}};
         m_valid_q <= 1'b0;
         m_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign fifo_r_en = push;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign words_out = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed, table-driven bench for fifo_rd_stream; the FIFO side is emulated
// by hand in each vector (fifo_empty/fifo_data as the FIFO would present them).
module tb_fifo_rd_stream;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk_r = 1'b0;
   logic          rst;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_r_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          flush;
   logic [CW-1:0] words_out;

   int checks = 0;
   int errors = 0;

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk_r      (clk_r),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .flush      (flush),
      .words_out  (words_out)
   );

   always #5 clk_r = ~clk_r;

   typedef struct {
      logic          rst;
      logic          flush;
      logic          rdy;
      logic          emp;
      logic [DW-1:0] din;
      logic          ren;
      logic          vld;
      logic [DW-1:0] dat;
      logic [CW-1:0] cnt;
      string         name;
   } vec_t;

   vec_t vecs[31];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then check that cycle's outputs.
   task automatic apply(input logic r, input logic f, input logic rd, input logic e, input logic [DW-1:0] d,
                        input logic x_ren, input logic x_vld, input logic [DW-1:0] x_dat, input logic [CW-1:0] x_cnt,
                        input string name, input int idx);
      @(posedge clk_r);
      #1;
      rst        = r;
      flush      = f;
      m_ready    = rd;
      fifo_empty = e;
      fifo_data  = d;
      #1;
      check({name, ".r_en"},  idx, {31'd0, fifo_r_en}, {31'd0, x_ren});
      check({name, ".valid"}, idx, {31'd0, m_valid},   {31'd0, x_vld});
      check({name, ".data"},  idx, {24'd0, m_data},    {24'd0, x_dat});
      check({name, ".count"}, idx, {28'd0, words_out}, {28'd0, x_cnt});
   endtask

   function automatic vec_t mk(input logic r, input logic f, input logic rd, input logic e, input logic [7:0] d,
                               input logic xr, input logic xv, input logic [7:0] xd, input logic [3:0] xc,
                               input string n);
      vec_t v;
      v.rst = r; v.flush = f; v.rdy = rd; v.emp = e; v.din = d;
      v.ren = xr; v.vld = xv; v.dat = xd; v.cnt = xc; v.name = n;
      return v;
   endfunction

   initial begin
      //               rst   fl    rdy   emp   din     ren   vld   dat     cnt
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 4'd0, "reset");
      vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 4'd0, "reset");
      vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 4'd0, "stream");
      vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 8'h11, 4'd0, "stream");
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'h22, 4'd1, "stream");
      vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h33, 4'd2, "stream");
      vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'd3, "stream");
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 4'd3, "bp");
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 8'h11, 4'd3, "bp");
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'h11, 4'd3, "bp");
      vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'h11, 4'd3, "bp");
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 8'h11, 4'd3, "bp");
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'h22, 4'd4, "bp");
      vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 8'h33, 4'd5, "bp");
      vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h44, 4'd6, "bp");
      vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'd7, "bp");
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 8'h00, 4'd7, "flush");
      vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 1'b1, 1'b1, 8'h55, 4'd7, "flush");
      vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 8'h55, 4'd7, "flush");
      vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 4'd7, "flush");
      vecs[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h77, 4'd7, "flush");
      vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'd8, "flush");
      vecs[22] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h88, 1'b1, 1'b0, 8'h00, 4'd8, "flushpop");
      vecs[23] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 8'h88, 4'd8, "flushpop");
      vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 4'd9, "flushpop");
      vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h99, 4'd9, "flushpop");
      vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b1, 8'h99, 4'd9, "midrst");
      vecs[27] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 8'h99, 4'd9, "midrst");
      vecs[28] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b0, 8'h00, 4'd0, "midrst");
      vecs[29] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA2, 4'd0, "midrst");
      vecs[30] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1, "midrst");

      rst        = 1'b1;
      flush      = 1'b0;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      repeat (2) @(posedge clk_r);

      for (int i = 0; i < 31; i++) begin
         apply(vecs[i].rst, vecs[i].flush, vecs[i].rdy, vecs[i].emp, vecs[i].din,
               vecs[i].ren, vecs[i].vld, vecs[i].dat, vecs[i].cnt, vecs[i].name, i);
      end

      // Continuous stream from EMPTY with count 1: first cycle fills, then one pop per cycle.
      // Count at cycle k>=1 is k mod 16, so it passes 15 -> 0 -> 1 at k = 15, 16, 17.
      for (int k = 0; k < 19; k++) begin
         logic [7:0] din_k;
         logic [7:0] dat_k;
         logic [3:0] cnt_k;
         din_k = 8'h30 + 8'(k);
         dat_k = (k == 0) ? 8'h00 : 8'h30 + 8'(k - 1);
         cnt_k = (k == 0) ? 4'd1 : 4'(k);
         apply(1'b0, 1'b0, 1'b1, 1'b0, din_k, 1'b1, (k != 0), dat_k, cnt_k, "wrap", k);
      end
      apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h42, 4'd3, "wrap", 19);
      apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'd4, "wrap", 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
